// File: rtl/quadrature_generator_pkg.sv
// Definitions shared by the quadrature generator and the incremental decoder:
// direction encoding, FSM states and the 2-bit Gray step function.
package quadrature_generator_pkg;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // {A,B} CW order 00->01->11->10->00; CCW walks the same ring backwards.
    function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic dir);
        logic [1:0] nxt;
        if (dir == DIR_CW) begin
            nxt = {ab[0], ~ab[1]};
        end else begin
            nxt = {~ab[0], ab[1]};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quadrature_generator_timer.sv
// Edge-period down-counter: ticks for one cycle every load_value cycles while
// enabled, reloading itself on each tick; a load value of 0 behaves as 1.
module quad_edge_timer #(
    parameter int divwidth = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                load,
    input  logic                enable,
    input  logic [divwidth-1:0] load_value,
    output logic                tick
);

    localparam logic [divwidth-1:0] ONE = {{(divwidth-1){1'b0}}, 1'b1};

    logic [divwidth-1:0] count_q;
    logic [divwidth-1:0] count_d;
    logic [divwidth-1:0] reload;

    always_comb begin
        reload  = (load_value == '0) ? ONE : load_value;
        tick    = enable && (count_q == ONE);
        count_d = count_q;
        if (load || tick) begin
            count_d = reload;
        end else if (enable) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= ONE;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/quadrature_generator.sv
// Quadrature encoder emulator: turns a signed step command into A/B/I edges
// at Clock/Period, tracking Position with the decoder's CPR wrap rules.
module quadrature_generator
    import quadrature_generator_pkg::*;
#(
    parameter int buswidth = 32,
    parameter int divwidth = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [buswidth-1:0]        DataBus,
    input  logic                       SetCPR,
    input  logic                       SetPosition,
    input  logic                       SetPeriod,
    input  logic                       Move,
    input  logic                       Abort,
    output logic                       A,
    output logic                       B,
    output logic                       I,
    output logic signed [buswidth-1:0] Position,
    output logic                       Busy,
    output logic                       Done
);

    localparam logic [buswidth-1:0] BUS_ONE = {{(buswidth-1){1'b0}}, 1'b1};
    localparam logic [divwidth-1:0] DIV_ONE = {{(divwidth-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [buswidth-1:0] remaining_q, remaining_d;
    logic                dir_q, dir_d;
    logic [buswidth-1:0] position_q, position_d;
    logic [buswidth-1:0] cpr_q, cpr_d;
    logic [divwidth-1:0] period_q, period_d;
    logic [1:0]          ab_q, ab_d;
    logic                i_q, i_d;
    logic                done_q, done_d;

    logic                tick;
    logic                timer_load;
    logic [buswidth-1:0] stepped_position;
    logic                move_negative;

    quad_edge_timer #(
        .divwidth(divwidth)
    ) u_timer (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (timer_load),
        .enable    (state_q == RUN),
        .load_value(period_q),
        .tick      (tick)
    );

    // CPR of 0 means an unbounded two's-complement position.
    always_comb begin
        stepped_position = position_q - BUS_ONE;
        if (dir_q == DIR_CW) begin
            if ((cpr_q != '0) && (position_q == cpr_q - BUS_ONE)) begin
                stepped_position = '0;
            end else begin
                stepped_position = position_q + BUS_ONE;
            end
        end else if ((cpr_q != '0) && (position_q == '0)) begin
            stepped_position = cpr_q - BUS_ONE;
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        dir_d         = dir_q;
        position_d    = position_q;
        cpr_d         = cpr_q;
        period_d      = period_q;
        ab_d          = ab_q;
        done_d        = 1'b0;
        timer_load    = 1'b0;
        move_negative = DataBus[buswidth-1];

        unique case (state_q)
            IDLE: begin
                if (SetCPR)      cpr_d      = DataBus;
                if (SetPosition) position_d = DataBus;
                if (SetPeriod)   period_d   = DataBus[divwidth-1:0];
                if (Move && !Abort) begin
                    if (DataBus == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        dir_d       = move_negative ? DIR_CCW : DIR_CW;
                        // Negating the most-negative value yields 2^(buswidth-1) unsigned.
                        remaining_d = move_negative ? (~DataBus + BUS_ONE) : DataBus;
                        timer_load  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (Abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (tick) begin
                    ab_d        = next_ab(ab_q, dir_q);
                    position_d  = stepped_position;
                    remaining_d = remaining_q - BUS_ONE;
                    if (remaining_q == BUS_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        i_d = (cpr_d != '0) && (position_d == '0);
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            dir_q       <= DIR_CW;
            position_q  <= '0;
            cpr_q       <= '0;
            period_q    <= DIV_ONE;
            ab_q        <= 2'b00;
            i_q         <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            position_q  <= position_d;
            cpr_q       <= cpr_d;
            period_q    <= period_d;
            ab_q        <= ab_d;
            i_q         <= i_d;
            done_q      <= done_d;
        end
    end

    assign A        = ab_q[1];
    assign B        = ab_q[0];
    assign I        = i_q;
    assign Position = position_q;
    assign Busy     = (state_q == RUN);
    assign Done     = done_q;

endmodule

// File: doc/quadrature_generator.md
# quadrature_generator

Synchronous quadrature encoder emulator: accepts a signed step command and produces A/B/I waveforms at a programmable edge rate. It feeds the incremental encoder decoder during bring-up and loopback test, and drives simulated motor feedback. Each emitted edge is one count in the decoder's 4x convention. CPR wrap and the index pulse match the decoder's behaviour, so both blocks agree on Position.

## Interface
Parameters:
- `buswidth`, 32: width of DataBus, Position and CPR.
- `divwidth`, 16: width of the edge-period register.

Ports:
- `Clock`  in  1: the single block clock.
- `Reset`  in  1: synchronous, active-high.
- `DataBus`  in  buswidth: load value for the Set*/Move commands.
- `SetCPR`  in  1: load CPR from DataBus. 0 disables wrap and index.
- `SetPosition`  in  1: load Position from DataBus.
- `SetPeriod`  in  1: load Period from DataBus[divwidth-1:0]. Clocks per edge; 0 is treated as 1.
- `Move`  in  1: start a move of signed DataBus counts. Positive = CW.
- `Abort`  in  1: stop the current move.
- `A`, `B`, `I`  out  1 each: quadrature and index outputs, registered.
- `Position`  out  buswidth, signed: emulated position after each emitted edge.
- `Busy`  out  1: a move is in progress.
- `Done`  out  1: one-cycle pulse when a move completes normally.

## Operation
- Reset values:
  - A=0, B=0, I=0.
  - Position=0, Busy=0, Done=0.
  - CPR=0, Period=1, state IDLE.
- Quadrature sequence, shown as {A,B}:
  - CW: 00→01→11→10→00.
  - CCW: the reverse.
  - This matches the decoder: posedge A with B=1 is CW; posedge B with A=0 is CW.
- Exactly one of A or B toggles per emitted edge.
- FSM states: IDLE and RUN.
- IDLE, on Move:
  - Direction = sign of DataBus.
  - Remaining = |DataBus|, unsigned buswidth. The most-negative value gives 2^(buswidth-1) steps.
  - Go to RUN and load the timer with Period.
  - If DataBus=0: stay IDLE, assert Done next cycle, emit no edge.
- RUN:
  - The timer decrements each cycle.
  - On expiry: emit one edge, update Position, decrement Remaining, reload the timer.
  - When Remaining reaches 0: go to IDLE and assert Done.
- Position update, CW:
  - If CPR≠0 and Position==CPR-1: Position=0.
  - Otherwise Position+1, wrapping two's complement.
- Position update, CCW:
  - If CPR≠0 and Position==0: Position=CPR-1.
  - Otherwise Position-1.
- I = (CPR≠0) && (Position==0).
  - Registered together with A/B, so it changes on the same edge as the entering count.
- Abort in RUN:
  - Go to IDLE and clear Remaining.
  - No Done; A/B/I/Position hold.
- Priorities, same cycle:
  - Reset > Abort > Move.
  - Move, SetCPR, SetPosition and SetPeriod are ignored while Busy or in the cycle Busy deasserts.
  - Multiple Set* strobes in one IDLE cycle all load from the same DataBus.
- SetPosition in IDLE: loads Position as-is (not reduced mod CPR). I follows the new value.
- Period changes take effect on the next Move only.

## Timing
- Move sampled at clock edge t0 → Busy=1 from t0.
- First edge registered at t0+Period.
- Subsequent edges are Period cycles apart. Edge rate = Clock/Period.
- Last edge at t0+N·Period. On the same clock edge: Busy→0 and Done→1 for exactly one cycle.
- Next Move is accepted from the cycle after Busy=0.
- Set* commands take effect at the next clock edge, visible on Position/I the following cycle.
- A/B/I are glitch-free flops with no combinational path from inputs.

## Structure
- Shared package (shared with the decoder):
  - Dir_CW=1, Dir_CCW=0.
  - FSM state enum {IDLE, RUN}.
  - The 2-bit Gray step function next_ab(ab, dir).
- Sub-module `quad_edge_timer`:
  - divwidth down-counter with load, enable and a one-cycle `tick` output.
  - Load value of 0 is coerced to 1.
- Top level holds the FSM, Remaining, the Position/CPR arithmetic and the output registers.

## Test plan
- Reset, then Period=4, Move=+8:
  - {A,B} = 01,11,10,00,01,11,10,00 at cycles 4,8,…,32.
  - Position ends at 8; Done pulses at cycle 32; Busy high for cycles 0–31.
- CPR=100, Position=98, Move=+3:
  - Position 99, 0, 1.
  - I=1 only while Position==0, for exactly one Period interval.
- CPR=100, Position=0, Move=-2:
  - Position 99, 98, with CCW order 00→10→11.
  - I drops on the first edge.
- Move=0: no A/B activity; Done pulses one cycle later; Busy stays 0.
- Period=1, Move=+1000, Abort at cycle 500:
  - Exactly 499 or 500 edges, per sampling edge.
  - No Done; outputs hold; a Move issued during RUN is ignored.
- Loopback into the decoder with a random Period in 1–7 and a random signed Move (including -2^31 truncated by Abort): decoder Position equals generator Position after every edge.
